watch_timer: RTL

- Parametrised successor to the mm:ss stopwatch: a single-clock stopwatch/countdown timer with internal 1 Hz-class prescaler, BCD mm:ss counter, start/pause/clear control FSM, preset load, lap freeze and registered 7-segment outputs.
- Sits at the top of the watch display path and drives four 8-bit segment buses directly.

---
 rtl/watch_timer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/watch_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// watch_timer : BCD mm:ss stopwatch / countdown with lap freeze and 7-seg out
// Revision    : 1.0
// ---------------------------------------------------------------------------
module watch_timer #(
   parameter int CLK_HZ         = 100000000,
   parameter int TICK_HZ        = 1,
   parameter int MIN_WRAP       = 60,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       mode,
   input  logic       load,
   input  logic [7:0] preset_min,
   input  logic [7:0] preset_sec,
   input  logic       lap,
   output logic [7:0] seg_minutes_tens,
   output logic [7:0] seg_minutes_units,
   output logic [7:0] seg_seconds_tens,
   output logic [7:0] seg_seconds_units,
   output logic       running,
   output logic       expired
);

   localparam int             TERM_I   = CLK_HZ / TICK_HZ - 1;
   localparam int             PW       = (TERM_I > 0) ? $clog2(TERM_I + 1) : 1;
   localparam logic [PW-1:0]  TERM     = TERM_I[PW-1:0];
   localparam logic [3:0]     MT_MAX   = 4'(MIN_WRAP / 10 - 1);
   localparam logic [7:0]     SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   state_t        state, state_n;
   logic [15:0]   count, count_n, lap_reg, lap_reg_n, stepped, src;
   logic [PW-1:0] presc, presc_n;
   logic          run_dir, run_dir_n, lap_hold, lap_hold_n;
   logic          tick, preset_valid, colon;

   // count layout is {min_tens, min_units, sec_tens, sec_units}
   function automatic logic [15:0] step_up(input logic [15:0] c);
      logic [15:0] r;
      r = c;
      if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (c[7:4] != 4'd5) r[7:4] = c[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (c[11:8] != 4'd9) r[11:8] = c[11:8] + 4'd1;
            else begin
               r[11:8]  = 4'd0;
               r[15:12] = (c[15:12] == MT_MAX) ? 4'd0 : c[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] step_down(input logic [15:0] c);
      logic [15:0] r;
      r = c;
      if (c[3:0] != 4'd0) r[3:0] = c[3:0] - 4'd1;
      else begin
         r[3:0] = 4'd9;
         if (c[7:4] != 4'd0) r[7:4] = c[7:4] - 4'd1;
         else begin
            r[7:4] = 4'd5;
            if (c[11:8] != 4'd0) r[11:8] = c[11:8] - 4'd1;
            else begin
               r[11:8]  = 4'd9;
               r[15:12] = (c[15:12] == 4'd0) ? MT_MAX : c[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'h3F;
         4'd1:    s = 8'h06;
         4'd2:    s = 8'h5B;
         4'd3:    s = 8'h4F;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'h6D;
         4'd6:    s = 8'h7D;
         4'd7:    s = 8'h07;
         4'd8:    s = 8'h7F;
         4'd9:    s = 8'h6F;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   assign tick         = (state == RUN) && (presc == TERM);
   assign stepped      = run_dir ? step_down(count) : step_up(count);
   assign preset_valid = (preset_sec[3:0] <= 4'd9) && (preset_sec[7:4] <= 4'd5) &&
                         (preset_min[3:0] <= 4'd9) && (preset_min[7:4] <= MT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         lap_reg  <= '0;
         presc    <= '0;
         run_dir  <= 1'b0;
         lap_hold <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         lap_reg  <= lap_reg_n;
         presc    <= presc_n;
         run_dir  <= run_dir_n;
         lap_hold <= lap_hold_n;
      end
   end

   // Ignored commands fall through so the next lower-priority input still acts.
   always_comb begin
      state_n    = state;
      count_n    = count;
      lap_reg_n  = lap_reg;
      presc_n    = presc;
      run_dir_n  = run_dir;
      lap_hold_n = lap_hold;
      if (clear) begin
         state_n    = IDLE;
         count_n    = '0;
         presc_n    = '0;
         lap_hold_n = 1'b0;
      end else if (load && (state != RUN) && preset_valid) begin
         state_n = IDLE;
         count_n = {preset_min, preset_sec};
         presc_n = '0;
      end else if (start && (state == IDLE) && !(mode && (count == 16'h0000))) begin
         state_n   = RUN;
         run_dir_n = mode;
         presc_n   = '0;
      end else if (start && (state == PAUSED)) begin
         state_n = RUN;
      end else if (pause && (state == RUN)) begin
         state_n = PAUSED;
      end else if (state == RUN) begin
         presc_n = tick ? '0 : presc + 1'b1;
         if (tick) begin
            count_n = stepped;
            if (run_dir && (stepped == 16'h0000)) state_n = DONE;
         end
         if (lap) begin
            lap_hold_n = !lap_hold;
            if (!lap_hold) lap_reg_n = count;
         end
      end else if (lap) begin
         lap_hold_n = 1'b0;
      end
   end

   assign src   = lap_hold ? lap_reg : count;
   assign colon = (state == RUN) || (state == PAUSED);

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_minutes_tens  <= 8'h3F ^ SEG_MASK;
         seg_minutes_units <= 8'h3F ^ SEG_MASK;
         seg_seconds_tens  <= 8'h3F ^ SEG_MASK;
         seg_seconds_units <= 8'h3F ^ SEG_MASK;
         running           <= 1'b0;
         expired           <= 1'b0;
      end else begin
         seg_minutes_tens  <= seg7(src[15:12]) ^ SEG_MASK;
         seg_minutes_units <= ({colon, 7'b0} | seg7(src[11:8])) ^ SEG_MASK;
         seg_seconds_tens  <= seg7(src[7:4]) ^ SEG_MASK;
         seg_seconds_units <= seg7(src[3:0]) ^ SEG_MASK;
         running           <= (state == RUN);
         expired           <= (state == DONE);
      end
   end

endmodule
`default_nettype wire
